prbs_checker_16b: RTL

PRBS_CHECKER_16B -- requirements
Module: prbs_checker_16b

---
 rtl/prbs_chk_pkg.sv | 27 ++
 rtl/prbs31_predict16.sv | 21 ++
 rtl/prbs_checker_16b.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prbs_chk_pkg.sv
// Shared types and constants for the 16-bit PRBS31 checker.
// Purely declarative: no latency, no flow control.
package prbs_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   localparam int TAP_A  = 31;
   localparam int TAP_B  = 28;
   localparam int HIST_W = 32;
   localparam int WORD_W = 16;
   localparam int PC_W   = $clog2(WORD_W + 1);

   function automatic logic [PC_W-1:0] popcount_word(input logic [WORD_W-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < WORD_W; i++) begin
         c = c + {{(PC_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/prbs31_predict16.sv
// Next-word predictor for PRBS31 from a 32-bit history (bit 0 newest).
// Combinational, zero latency; no flow control.
module prbs31_predict16
   import prbs_chk_pkg::*;
(
   input  logic [HIST_W-1:0] hist,
   output logic [WORD_W-1:0] pred
);

   // Every bit of the next word depends only on history, since WORD_W < TAP_B.
   always_comb begin
      pred = '0;
      for (int k = 0; k < WORD_W; k++) begin
         pred[k] = hist[TAP_A-WORD_W+k] ^ hist[TAP_B-WORD_W+k];
      end
   end

   logic unused_hist_bits;
   assign unused_hist_bits = ^{hist[HIST_W-1], hist[TAP_B-WORD_W-1:0]};

endmodule

// File: rtl/prbs_checker_16b.sv
// PRBS31 16-bit parallel checker: seed, verify, lock, then count bit errors against a free-running reference.
// Outputs registered 1 cycle after an accepted word; no backpressure, din_valid only qualifies input.
module prbs_checker_16b
   import prbs_chk_pkg::*;
#(
   parameter int LOCK_WORDS  = 32,
   parameter int UNLOCK_ERRS = 4,
   parameter int WIN_WORDS   = 256,
   parameter int CNT_W       = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [15:0]       din,
   input  logic              din_valid,
   input  logic              inv,
   input  logic              clr_cnt,
   output logic              locked,
   output logic              err_word,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [1:0]        state
);

   localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
   localparam int WIN_W  = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
   localparam int ERRW_W = $clog2(UNLOCK_ERRS + 1);

   state_t              cur_st, nxt_st;
   logic [HIST_W-1:0]   hist;
   logic [WORD_W-1:0]   d, pred, miss, shift_word;
   logic [PC_W-1:0]     pc;
   logic                word_bad, acc, shift_en;
   logic                seed_cnt;
   logic [GOOD_W-1:0]   good_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [ERRW_W-1:0]   errw_cnt, errw_inc;
   logic                good_done, win_wrap, unlock, lock_acc;
   logic [CNT_W+PC_W-1:0] ec_sum;
   logic [CNT_W-1:0]    ec_next, wc_next;

   assign d        = inv ? ~din : din;
   assign miss     = d ^ pred;
   assign word_bad = |miss;
   assign pc       = popcount_word(miss);
   assign acc      = en && din_valid;

   prbs31_predict16 u_predict (
      .hist (hist),
      .pred (pred)
   );

   assign good_done = (good_cnt == GOOD_W'(LOCK_WORDS - 1));
   assign win_wrap  = (win_cnt == WIN_W'(WIN_WORDS - 1));
   assign errw_inc  = errw_cnt + {{(ERRW_W-1){1'b0}}, word_bad};
   assign unlock    = (errw_inc >= ERRW_W'(UNLOCK_ERRS));
   assign lock_acc  = acc && (cur_st == ST_LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st <= ST_IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   always_comb begin
      nxt_st     = cur_st;
      shift_en   = 1'b0;
      shift_word = d;
      if (!en) begin
         nxt_st = ST_IDLE;
      end else begin
         case (cur_st)
            ST_IDLE: nxt_st = ST_SEED;
            ST_SEED: begin
               shift_en = din_valid;
               if (din_valid && seed_cnt) nxt_st = ST_VERIFY;
            end
            ST_VERIFY: begin
               shift_en = din_valid;
               if (din_valid) begin
                  if (word_bad)       nxt_st = ST_SEED;
                  else if (good_done) nxt_st = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               // Once locked the reference free-runs on its own prediction.
               shift_en   = din_valid;
               shift_word = pred;
               if (din_valid && unlock) nxt_st = ST_SEED;
            end
            default: nxt_st = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
      end else if (shift_en) begin
         hist <= {hist[HIST_W-WORD_W-1:0], shift_word};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_cnt <= 1'b0;
         good_cnt <= '0;
      end else begin
         if (cur_st != ST_SEED) seed_cnt <= 1'b0;
         else if (acc)          seed_cnt <= ~seed_cnt;
         if (cur_st != ST_VERIFY) good_cnt <= '0;
         else if (acc)            good_cnt <= (word_bad || good_done) ? '0 : good_cnt + GOOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt  <= '0;
         errw_cnt <= '0;
      end else if (cur_st != ST_LOCKED) begin
         win_cnt  <= '0;
         errw_cnt <= '0;
      end else if (acc) begin
         win_cnt <= win_cnt + WIN_W'(1);
         if (unlock || win_wrap) errw_cnt <= '0;
         else                    errw_cnt <= errw_inc;
      end
   end

   assign ec_sum  = {{PC_W{1'b0}}, err_cnt} + {{CNT_W{1'b0}}, pc};
   assign ec_next = (|ec_sum[CNT_W+PC_W-1:CNT_W]) ? {CNT_W{1'b1}} : ec_sum[CNT_W-1:0];
   assign wc_next = (&word_cnt) ? word_cnt : word_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt  <= '0;
         word_cnt <= '0;
         err_word <= 1'b0;
      end else begin
         err_word <= acc && word_bad && (cur_st == ST_VERIFY || cur_st == ST_LOCKED);
         if (clr_cnt) begin
            err_cnt  <= '0;
            word_cnt <= '0;
         end else if (lock_acc) begin
            err_cnt  <= ec_next;
            word_cnt <= wc_next;
         end
      end
   end

   assign locked = (cur_st == ST_LOCKED);
   assign state  = cur_st;

endmodule
